rfid_reader_inventory_seq: RTL and testbench

Inventory-round sequencer sitting directly upstream of the reader packet rx/tx block. It drives that block's `send_packet_type`/`start_tx`/`tx_handle` inputs and consumes its `rx_packet_complete`/`rx_timeout`/`reader_running`/`rx_handle` outputs. One round is Query, then QueryRep for each further slot, with an ACK issued whenever an RN16 arrives, over 2^Q slots. Each ACKed tag handle is reported to the host logic together with round statistics.

---
 rtl/rfid_reader_inventory_seq_if.sv | 21 ++
 rtl/rfid_reader_inventory_seq.sv | 209 ++++++++++++++++++++
 tb/tb_rfid_reader_inventory_seq.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rfid_reader_inventory_seq_if.sv
// Link between the inventory sequencer (master) and the reader packet rx/tx block (slave).
// The master drives command code, start strobe and ACK handle; the slave returns status and RN16.
interface rfid_reader_inventory_seq_if;
    logic [3:0]  send_packet_type;
    logic        start_tx;
    logic [15:0] tx_handle;
    logic        rx_packet_complete;
    logic        rx_timeout;
    logic        reader_running;
    logic [15:0] rx_handle;

    modport master (
        output send_packet_type, start_tx, tx_handle,
        input  rx_packet_complete, rx_timeout, reader_running, rx_handle
    );

    modport slave (
        input  send_packet_type, start_tx, tx_handle,
        output rx_packet_complete, rx_timeout, reader_running, rx_handle
    );
endinterface

// File: rtl/rfid_reader_inventory_seq.sv
// Inventory-round sequencer: Query / QueryRep per slot, ACK on every RN16, reports ACKed handles.
// Handshake: start_tx is a one-cycle strobe (sent twice per command); events count only once armed by reader_running.
module rfid_reader_inventory_seq #(
    parameter logic [15:0] WATCHDOG_CYCLES = 16'd65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inv_start,
    input  logic        inv_abort,
    input  logic [3:0]  slot_q,
    rfid_reader_inventory_seq_if.master pkt,
    output logic        inv_busy,
    output logic        inv_done,
    output logic        tag_found,
    output logic [15:0] tag_handle,
    output logic [15:0] tag_count,
    output logic [15:0] slot_idx,
    output logic        watchdog_err,
    output logic [2:0]  dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_KICK1   = 3'd2,
        S_GAP     = 3'd3,
        S_KICK2   = 3'd4,
        S_WAIT    = 3'd5,
        S_CAPTURE = 3'd6
    } state_t;

    localparam logic [3:0]  CMD_QUERYREP = 4'd0;
    localparam logic [3:0]  CMD_ACK      = 4'd1;
    localparam logic [3:0]  CMD_QUERY    = 4'd2;
    localparam logic [15:0] WD_LAST      = WATCHDOG_CYCLES - 16'd1;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_q;
    logic [3:0]  r_cur_cmd;
    logic [15:0] r_tx_handle;
    logic [15:0] r_slot_idx;
    logic [15:0] r_tag_count;
    logic [15:0] r_tag_handle;
    logic [15:0] r_wd_cnt;
    logic        r_armed;
    logic        r_tag_found;
    logic        r_inv_done;
    logic        r_watchdog_err;
    logic [15:0] w_last_slot;

    logic w_start;
    logic w_latch_rn16;
    logic w_tag;
    logic w_advance;
    logic w_slot_next;
    logic w_round_done;
    logic w_wd_fire;

    assign w_last_slot = (16'd1 << r_q) - 16'd1;

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_latch_rn16 = 1'b0;
        w_tag        = 1'b0;
        w_advance    = 1'b0;
        w_slot_next  = 1'b0;
        w_round_done = 1'b0;
        w_wd_fire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (inv_start) begin
                    w_start      = 1'b1;
                    w_next_state = S_SETUP;
                end
            end
            S_SETUP: w_next_state = S_KICK1;
            S_KICK1: w_next_state = S_GAP;
            S_GAP:   w_next_state = S_KICK2;
            S_KICK2: w_next_state = S_WAIT;
            S_WAIT: begin
                // An accepted event always wins over the watchdog in the same cycle.
                if (r_armed && pkt.rx_packet_complete) begin
                    w_next_state = S_CAPTURE;
                end else if (r_armed && pkt.rx_timeout) begin
                    w_advance = 1'b1;
                end else if (r_wd_cnt == WD_LAST) begin
                    w_wd_fire    = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_CAPTURE: begin
                if (r_cur_cmd == CMD_ACK) begin
                    w_tag     = 1'b1;
                    w_advance = 1'b1;
                end else begin
                    w_latch_rn16 = 1'b1;
                    w_next_state = S_SETUP;
                end
            end
            default: w_next_state = S_IDLE;
        endcase

        if (w_advance) begin
            if (r_slot_idx == w_last_slot) begin
                w_round_done = 1'b1;
                w_next_state = S_IDLE;
            end else begin
                w_slot_next  = 1'b1;
                w_next_state = S_SETUP;
            end
        end

        if (inv_abort) begin
            w_next_state = S_IDLE;
            w_start      = 1'b0;
            w_latch_rn16 = 1'b0;
            w_tag        = 1'b0;
            w_slot_next  = 1'b0;
            w_round_done = 1'b0;
            w_wd_fire    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q            <= 4'd0;
            r_cur_cmd      <= CMD_QUERYREP;
            r_tx_handle    <= 16'd0;
            r_slot_idx     <= 16'd0;
            r_tag_count    <= 16'd0;
            r_tag_handle   <= 16'd0;
            r_wd_cnt       <= 16'd0;
            r_armed        <= 1'b0;
            r_tag_found    <= 1'b0;
            r_inv_done     <= 1'b0;
            r_watchdog_err <= 1'b0;
        end else begin
            r_tag_found <= 1'b0;
            r_inv_done  <= 1'b0;

            if (w_start) begin
                r_q            <= slot_q;
                r_slot_idx     <= 16'd0;
                r_tag_count    <= 16'd0;
                r_watchdog_err <= 1'b0;
                r_cur_cmd      <= CMD_QUERY;
            end

            // Arming and the watchdog restart on every entry to WAIT.
            if (r_state == S_KICK2 && w_next_state == S_WAIT) begin
                r_armed  <= 1'b0;
                r_wd_cnt <= 16'd0;
            end else if (r_state == S_WAIT) begin
                if (pkt.reader_running) begin
                    r_armed <= 1'b1;
                end
                r_wd_cnt <= r_wd_cnt + 16'd1;
            end

            if (w_latch_rn16) begin
                r_tx_handle <= pkt.rx_handle;
                r_cur_cmd   <= CMD_ACK;
            end

            if (w_tag) begin
                r_tag_found  <= 1'b1;
                r_tag_handle <= r_tx_handle;
                if (r_tag_count != 16'hFFFF) begin
                    r_tag_count <= r_tag_count + 16'd1;
                end
            end

            if (w_slot_next) begin
                r_slot_idx <= r_slot_idx + 16'd1;
                r_cur_cmd  <= CMD_QUERYREP;
            end

            if (w_round_done) begin
                r_inv_done <= 1'b1;
            end

            if (w_wd_fire) begin
                r_watchdog_err <= 1'b1;
                r_inv_done     <= 1'b1;
            end
        end
    end

    assign pkt.send_packet_type = r_cur_cmd;
    assign pkt.start_tx         = ((r_state == S_KICK1) || (r_state == S_KICK2)) && !inv_abort;
    assign pkt.tx_handle        = r_tx_handle;
    assign inv_busy             = (r_state != S_IDLE);
    assign inv_done             = r_inv_done;
    assign tag_found            = r_tag_found;
    assign tag_handle           = r_tag_handle;
    assign tag_count            = r_tag_count;
    assign slot_idx             = r_slot_idx;
    assign watchdog_err         = r_watchdog_err;
    assign dbg_state            = r_state;
endmodule

// File: tb/tb_rfid_reader_inventory_seq.sv
// Directed bench for the inventory sequencer; the packet rx/tx block is emulated by tasks.
`timescale 1ns/1ps
module tb_rfid_reader_inventory_seq;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_KICK1   = 3'd2;
    localparam logic [2:0] ST_GAP     = 3'd3;
    localparam logic [2:0] ST_WAIT    = 3'd5;
    localparam logic [2:0] ST_CAPTURE = 3'd6;

    logic        clk = 1'b0;
    logic        reset;
    logic        inv_start;
    logic        inv_abort;
    logic [3:0]  slot_q;
    logic        inv_busy;
    logic        inv_done;
    logic        tag_found;
    logic [15:0] tag_handle;
    logic [15:0] tag_count;
    logic [15:0] slot_idx;
    logic        watchdog_err;
    logic [2:0]  dut_state;

    int checks = 0;
    int errors = 0;

    logic [3:0] cmd_log[$];
    int         cyc_log[$];
    logic [3:0] exp_q[$];
    int         cyc = 0;
    int         done_cnt = 0;
    int         found_cnt = 0;

    always #64 clk = ~clk;

    rfid_reader_inventory_seq_if pkt ();

    rfid_reader_inventory_seq #(.WATCHDOG_CYCLES(16'd100)) dut (
        .clk          (clk),
        .reset        (reset),
        .inv_start    (inv_start),
        .inv_abort    (inv_abort),
        .slot_q       (slot_q),
        .pkt          (pkt.master),
        .inv_busy     (inv_busy),
        .inv_done     (inv_done),
        .tag_found    (tag_found),
        .tag_handle   (tag_handle),
        .tag_count    (tag_count),
        .slot_idx     (slot_idx),
        .watchdog_err (watchdog_err),
        .dbg_state    (dut_state)
    );

    // Strobe/pulse monitor on the inactive edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (pkt.start_tx === 1'b1) begin
            cmd_log.push_back(pkt.send_packet_type);
            cyc_log.push_back(cyc);
        end
        if (inv_done === 1'b1) done_cnt <= done_cnt + 1;
        if (tag_found === 1'b1) found_cnt <= found_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "bench timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] st, input int max_cyc);
        int n = 0;
        while (dut_state !== st && n < max_cyc) begin
            tick();
            n++;
        end
        checks++;
        if (dut_state !== st) begin
            errors++;
            $display("FAIL wait_state got %0d exp %0d", dut_state, st);
        end
    endtask

    task automatic start_round(input logic [3:0] q);
        slot_q    = q;
        inv_start = 1'b1;
        tick();
        inv_start = 1'b0;
    endtask

    task automatic respond_timeout;
        pkt.reader_running = 1'b1;
        tick();
        pkt.rx_timeout = 1'b1;
        tick();
        pkt.rx_timeout     = 1'b0;
        pkt.reader_running = 1'b0;
    endtask

    task automatic respond_reply(input logic [15:0] h);
        pkt.reader_running = 1'b1;
        tick();
        pkt.rx_packet_complete = 1'b1;
        tick();
        pkt.rx_packet_complete = 1'b0;
        pkt.rx_handle          = h;
        tick();
        pkt.reader_running = 1'b0;
    endtask

    task automatic check_log(input string name, input int base);
        checks++;
        if (cmd_log.size() - base !== exp_q.size()) begin
            errors++;
            $display("FAIL %s_len got %0d exp %0d", name, cmd_log.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (cmd_log[base + i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s[%0d] got %0d exp %0d", name, i, cmd_log[base + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({pkt.start_tx, pkt.send_packet_type, pkt.tx_handle, inv_busy, inv_done, tag_found}
            !== 24'd0) begin
            errors++;
            $display("FAIL reset_pkt got %h exp 0",
                     {pkt.start_tx, pkt.send_packet_type, pkt.tx_handle, inv_busy, inv_done, tag_found});
        end
        checks++;
        if ({tag_handle, tag_count, slot_idx, watchdog_err, dut_state} !== 52'd0) begin
            errors++;
            $display("FAIL reset_host got %h exp 0", {tag_handle, tag_count, slot_idx, watchdog_err, dut_state});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_q0_tag;
        int lb = cmd_log.size();
        int db = done_cnt;
        int fb = found_cnt;
        start_round(4'd0);
        checks++;
        if ({pkt.start_tx, inv_busy, pkt.send_packet_type} !== 6'b01_0010) begin
            errors++;
            $display("FAIL q0_setup got %b exp 010010", {pkt.start_tx, inv_busy, pkt.send_packet_type});
        end
        tick();
        checks++;
        if (pkt.start_tx !== 1'b1) begin errors++; $display("FAIL q0_kick1 got %b exp 1", pkt.start_tx); end
        tick();
        checks++;
        if (pkt.start_tx !== 1'b0) begin errors++; $display("FAIL q0_gap got %b exp 0", pkt.start_tx); end
        tick();
        checks++;
        if (pkt.start_tx !== 1'b1) begin errors++; $display("FAIL q0_kick2 got %b exp 1", pkt.start_tx); end
        tick();
        checks++;
        if (dut_state !== ST_WAIT) begin errors++; $display("FAIL q0_wait got %0d exp %0d", dut_state, ST_WAIT); end
        respond_reply(16'hA5C3);
        checks++;
        if ({dut_state, pkt.tx_handle, pkt.send_packet_type} !== {ST_SETUP, 16'hA5C3, 4'd1}) begin
            errors++;
            $display("FAIL q0_rn16 got %h exp %h", {dut_state, pkt.tx_handle, pkt.send_packet_type},
                     {ST_SETUP, 16'hA5C3, 4'd1});
        end
        wait_state(ST_WAIT, 8);
        respond_reply(16'h3000);
        checks++;
        if ({tag_found, tag_handle, tag_count, inv_done, inv_busy} !== {1'b1, 16'hA5C3, 16'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL q0_found got %h exp %h", {tag_found, tag_handle, tag_count, inv_done, inv_busy},
                     {1'b1, 16'hA5C3, 16'd1, 1'b1, 1'b0});
        end
        tick();
        checks++;
        if ({tag_found, inv_done} !== 2'b00) begin
            errors++;
            $display("FAIL q0_pulse_len got %b exp 00", {tag_found, inv_done});
        end
        exp_q = {4'd2, 4'd2, 4'd1, 4'd1};
        check_log("q0_cmds", lb);
        checks++;
        if (cyc_log.size() >= lb + 4 &&
            (cyc_log[lb + 1] - cyc_log[lb] !== 2 || cyc_log[lb + 3] - cyc_log[lb + 2] !== 2)) begin
            errors++;
            $display("FAIL q0_strobe_gap got %0d,%0d exp 2,2",
                     cyc_log[lb + 1] - cyc_log[lb], cyc_log[lb + 3] - cyc_log[lb + 2]);
        end
        checks++;
        if (found_cnt - fb !== 1 || done_cnt - db !== 1) begin
            errors++;
            $display("FAIL q0_counts got found %0d done %0d exp 1 1", found_cnt - fb, done_cnt - db);
        end
    endtask

    task automatic test_q2_timeouts;
        int lb = cmd_log.size();
        start_round(4'd2);
        for (int i = 0; i < 4; i++) begin
            wait_state(ST_WAIT, 8);
            checks++;
            if (slot_idx !== 16'(i)) begin errors++; $display("FAIL q2_slot got %0d exp %0d", slot_idx, i); end
            respond_timeout();
        end
        checks++;
        if ({inv_done, inv_busy, tag_count, slot_idx} !== {1'b1, 1'b0, 16'd0, 16'd3}) begin
            errors++;
            $display("FAIL q2_end got %h exp %h", {inv_done, inv_busy, tag_count, slot_idx},
                     {1'b1, 1'b0, 16'd0, 16'd3});
        end
        tick();
        exp_q = {4'd2, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        check_log("q2_cmds", lb);
    endtask

    task automatic test_q1_ack_timeout;
        int lb = cmd_log.size();
        int fb = found_cnt;
        start_round(4'd1);
        wait_state(ST_WAIT, 8);
        respond_timeout();
        wait_state(ST_WAIT, 8);
        respond_reply(16'h0BEE);
        checks++;
        if ({pkt.tx_handle, pkt.send_packet_type} !== {16'h0BEE, 4'd1}) begin
            errors++;
            $display("FAIL q1_rn16 got %h exp %h", {pkt.tx_handle, pkt.send_packet_type}, {16'h0BEE, 4'd1});
        end
        wait_state(ST_WAIT, 8);
        respond_timeout();
        checks++;
        if ({inv_done, tag_found, tag_count} !== {1'b1, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL q1_end got %h exp %h", {inv_done, tag_found, tag_count}, {1'b1, 1'b0, 16'd0});
        end
        tick();
        checks++;
        if (found_cnt - fb !== 0) begin errors++; $display("FAIL q1_found got %0d exp 0", found_cnt - fb); end
        exp_q = {4'd2, 4'd2, 4'd0, 4'd0, 4'd1, 4'd1};
        check_log("q1_cmds", lb);
    endtask

    task automatic test_simultaneous;
        start_round(4'd0);
        wait_state(ST_WAIT, 8);
        pkt.reader_running = 1'b1;
        tick();
        pkt.rx_packet_complete = 1'b1;
        pkt.rx_timeout         = 1'b1;
        tick();
        checks++;
        if (dut_state !== ST_CAPTURE) begin
            errors++;
            $display("FAIL simul_capture got %0d exp %0d", dut_state, ST_CAPTURE);
        end
        pkt.rx_packet_complete = 1'b0;
        pkt.rx_timeout         = 1'b0;
        pkt.rx_handle          = 16'h5A5A;
        tick();
        pkt.reader_running = 1'b0;
        checks++;
        if ({pkt.tx_handle, pkt.send_packet_type} !== {16'h5A5A, 4'd1}) begin
            errors++;
            $display("FAIL simul_ack got %h exp %h", {pkt.tx_handle, pkt.send_packet_type}, {16'h5A5A, 4'd1});
        end
        wait_state(ST_WAIT, 8);
        respond_timeout();
        checks++;
        if ({inv_done, tag_count} !== {1'b1, 16'd0}) begin
            errors++;
            $display("FAIL simul_end got %h exp %h", {inv_done, tag_count}, {1'b1, 16'd0});
        end
    endtask

    task automatic test_stale_watchdog;
        logic bad = 1'b0;
        start_round(4'd0);
        wait_state(ST_WAIT, 8);
        pkt.rx_timeout = 1'b1;
        for (int k = 1; k < 100; k++) begin
            tick();
            if (dut_state !== ST_WAIT || inv_done !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin errors++; $display("FAIL stale_ignored got left WAIT exp held 99 cycles"); end
        tick();
        checks++;
        if ({inv_done, watchdog_err, inv_busy} !== 3'b110) begin
            errors++;
            $display("FAIL watchdog got %b exp 110", {inv_done, watchdog_err, inv_busy});
        end
        pkt.rx_timeout = 1'b0;
        tick();
        checks++;
        if (watchdog_err !== 1'b1) begin errors++; $display("FAIL wd_sticky got %b exp 1", watchdog_err); end
        start_round(4'd0);
        checks++;
        if (watchdog_err !== 1'b0) begin errors++; $display("FAIL wd_clear got %b exp 0", watchdog_err); end
        wait_state(ST_WAIT, 8);
        respond_timeout();
    endtask

    task automatic test_abort;
        int lb;
        int db;
        tick();
        lb = cmd_log.size();
        db = done_cnt;
        start_round(4'd1);
        wait_state(ST_WAIT, 8);
        respond_timeout();
        tick();
        tick();
        checks++;
        if (dut_state !== ST_GAP) begin errors++; $display("FAIL abort_gap got %0d exp %0d", dut_state, ST_GAP); end
        inv_abort = 1'b1;
        tick();
        inv_abort = 1'b0;
        checks++;
        if ({dut_state, inv_busy, inv_done, slot_idx} !== {ST_IDLE, 1'b0, 1'b0, 16'd1}) begin
            errors++;
            $display("FAIL abort_idle got %h exp %h", {dut_state, inv_busy, inv_done, slot_idx},
                     {ST_IDLE, 1'b0, 1'b0, 16'd1});
        end
        tick();
        tick();
        exp_q = {4'd2, 4'd2, 4'd0};
        check_log("abort_cmds", lb);
        checks++;
        if (done_cnt - db !== 0) begin errors++; $display("FAIL abort_done got %0d exp 0", done_cnt - db); end
        start_round(4'd0);
        tick();
        checks++;
        if (pkt.start_tx !== 1'b1) begin errors++; $display("FAIL abort_kick1 got %b exp 1", pkt.start_tx); end
        inv_abort = 1'b1;
        #1;
        checks++;
        if (pkt.start_tx !== 1'b0) begin errors++; $display("FAIL abort_force got %b exp 0", pkt.start_tx); end
        tick();
        inv_abort = 1'b0;
        checks++;
        if (dut_state !== ST_IDLE) begin errors++; $display("FAIL abort_k1_idle got %0d exp 0", dut_state); end
    endtask

    task automatic test_start_busy;
        start_round(4'd0);
        wait_state(ST_WAIT, 8);
        slot_q    = 4'd3;
        inv_start = 1'b1;
        tick();
        tick();
        checks++;
        if ({dut_state, inv_busy} !== {ST_WAIT, 1'b1}) begin
            errors++;
            $display("FAIL busy_start got %h exp %h", {dut_state, inv_busy}, {ST_WAIT, 1'b1});
        end
        inv_start = 1'b0;
        respond_timeout();
        checks++;
        if ({inv_done, slot_idx} !== {1'b1, 16'd0}) begin
            errors++;
            $display("FAIL busy_q got %h exp %h", {inv_done, slot_idx}, {1'b1, 16'd0});
        end
    endtask

    task automatic test_reset_mid;
        start_round(4'd0);
        wait_state(ST_WAIT, 8);
        respond_reply(16'hC0DE);
        wait_state(ST_WAIT, 8);
        checks++;
        if ({pkt.tx_handle, pkt.send_packet_type} !== {16'hC0DE, 4'd1}) begin
            errors++;
            $display("FAIL rst_pre got %h exp %h", {pkt.tx_handle, pkt.send_packet_type}, {16'hC0DE, 4'd1});
        end
        #20;
        reset = 1'b0;
        #5;
        checks++;
        if ({pkt.start_tx, pkt.send_packet_type, pkt.tx_handle, inv_busy, dut_state} !== 25'd0) begin
            errors++;
            $display("FAIL rst_async got %h exp 0",
                     {pkt.start_tx, pkt.send_packet_type, pkt.tx_handle, inv_busy, dut_state});
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        inv_start              = 1'b0;
        inv_abort              = 1'b0;
        slot_q                 = 4'd0;
        pkt.rx_packet_complete = 1'b0;
        pkt.rx_timeout         = 1'b0;
        pkt.reader_running     = 1'b0;
        pkt.rx_handle          = 16'd0;
        test_reset();
        test_q0_tag();
        test_q2_timeouts();
        test_q1_ack_timeout();
        test_simultaneous();
        test_stale_watchdog();
        test_abort();
        test_start_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
